// File: rtl/k_lsu_pkg.sv
// Shared types and helpers for the k_load_store_unit slice: access-size
// encodings, controller states, latched request payload and byte-lane mask.
package k_lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ACCESS,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } lsu_state_e;

    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsu_req_t;

    // Byte lanes touched by an access of the given size at byte offset off.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] m;
        case (size)
            SZ_BYTE: m = 4'b0001 << off;
            SZ_HALF: m = 4'b0011 << {off[1], 1'b0};
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/k_lsu_lane_mux.sv
// Byte-lane steering: extracts and extends load data from a memory word and
// merges right-justified store data into the addressed lanes of a word.
module k_lsu_lane_mux
    import k_lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data_c,
    output logic [31:0] merge_data_c
);

    logic [15:0] lane_c;
    logic [31:0] wrep_c;
    logic [3:0]  mask_c;

    // Load path: shift the addressed lanes down, then extend.
    always_comb begin
        lane_c      = 16'(rdata >> {off, 3'b000});
        load_data_c = rdata;
        case (size)
            SZ_BYTE: load_data_c = is_unsigned ? {24'h0, lane_c[7:0]}
                                               : {{24{lane_c[7]}}, lane_c[7:0]};
            SZ_HALF: load_data_c = is_unsigned ? {16'h0, lane_c}
                                               : {{16{lane_c[15]}}, lane_c};
            default: load_data_c = rdata;
        endcase
    end

    // Store path: replicate store data across lanes, keep unaddressed lanes.
    always_comb begin
        mask_c       = lane_mask(size, off);
        merge_data_c = rdata;
        case (size)
            SZ_BYTE: wrep_c = {4{wdata[7:0]}};
            SZ_HALF: wrep_c = {2{wdata[15:0]}};
            default: wrep_c = wdata;
        endcase
        for (int k = 0; k < 4; k++) begin
            if (mask_c[k]) begin
                merge_data_c[8*k +: 8] = wrep_c[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/k_load_store_unit.sv
// Load/store unit: byte/half/word accesses onto a word-wide memory with a
// combinational read port; sub-word stores are read-modify-write.
// Optional macro LSU_ALIGN_CHECK_EN enables misalignment errors; without it,
// low address bits are forced to the access alignment.
module k_load_store_unit
    import k_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              K_clk,
    input  logic              K_rst_n,
    input  logic              K_req_valid,
    output logic              K_req_ready,
    input  logic              K_req_write,
    input  logic [1:0]        K_req_size,
    input  logic              K_req_unsigned,
    input  logic [31:0]       K_req_addr,
    input  logic [31:0]       K_req_wdata,
    output logic              K_rsp_valid,
    output logic [31:0]       K_rsp_rdata,
    output logic              K_rsp_err,
    output logic [ADDR_W-1:0] K_mem_addr,
    output logic              K_mem_we,
    output logic [31:0]       K_mem_wdata,
    input  logic [31:0]       K_mem_rdata
);

    lsu_state_e        state_q, state_d;
    lsu_req_t          req_q, req_d;
    logic              ready_d, rsp_valid_d, rsp_err_d, mem_we_d;
    logic [31:0]       rsp_rdata_d, mem_wdata_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [1:0]        off_c;
    logic              req_err_c;
    logic [31:0]       load_data_c, merge_data_c;
    logic              unused_addr_bits;

    // Word index is taken straight from the request; only the byte offset is kept here.
    assign unused_addr_bits = ^req_q.addr[31:2];

    // Effective byte offset and error flag for the latched request.
    always_comb begin
        off_c     = req_q.addr[1:0];
        req_err_c = (req_q.size == SZ_ILL);
`ifdef LSU_ALIGN_CHECK_EN
        if (req_q.size == SZ_HALF && req_q.addr[0]) begin
            req_err_c = 1'b1;
        end
        if (req_q.size == SZ_WORD && req_q.addr[1:0] != 2'b00) begin
            req_err_c = 1'b1;
        end
`else
        if (req_q.size == SZ_HALF) begin
            off_c[0] = 1'b0;
        end
        if (req_q.size == SZ_WORD) begin
            off_c = 2'b00;
        end
`endif
    end

    k_lsu_lane_mux u_lane_mux (
        .off          (off_c),
        .size         (req_q.size),
        .is_unsigned  (req_q.uns),
        .rdata        (K_mem_rdata),
        .wdata        (req_q.wdata),
        .load_data_c  (load_data_c),
        .merge_data_c (merge_data_c)
    );

    always_ff @(posedge K_clk) begin
        if (!K_rst_n) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            K_req_ready <= 1'b1;
            K_rsp_valid <= 1'b0;
            K_rsp_rdata <= 32'h0;
            K_rsp_err   <= 1'b0;
            K_mem_we    <= 1'b0;
            K_mem_addr  <= '0;
            K_mem_wdata <= 32'h0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            K_req_ready <= ready_d;
            K_rsp_valid <= rsp_valid_d;
            K_rsp_rdata <= rsp_rdata_d;
            K_rsp_err   <= rsp_err_d;
            K_mem_we    <= mem_we_d;
            K_mem_addr  <= mem_addr_d;
            K_mem_wdata <= mem_wdata_d;
        end
    end

    // Outputs are computed for the state being entered so they line up with it.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        ready_d     = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'h0;
        rsp_err_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = K_mem_addr;
        mem_wdata_d = K_mem_wdata;
        case (state_q)
            ST_IDLE: begin
                if (K_req_valid) begin
                    req_d = '{write: K_req_write, size: K_req_size, uns: K_req_unsigned,
                              addr: K_req_addr, wdata: K_req_wdata};
                    mem_addr_d = K_req_addr[ADDR_W+1:2];
                    state_d    = ST_CHECK;
                end else begin
                    ready_d = 1'b1;
                end
            end
            ST_CHECK: begin
                if (req_err_c) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else if (!req_q.write || req_q.size == SZ_WORD) begin
                    state_d = ST_ACCESS;
                    if (req_q.write) begin
                        mem_we_d    = 1'b1;
                        mem_wdata_d = req_q.wdata;
                    end
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_ACCESS: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                if (!req_q.write) begin
                    rsp_rdata_d = load_data_c;
                end
            end
            ST_READ: begin
                state_d     = ST_WRITE;
                mem_we_d    = 1'b1;
                mem_wdata_d = merge_data_c;
            end
            ST_WRITE: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_k_load_store_unit.sv
// Scoreboard bench for k_load_store_unit: byte-level reference model, memory
// model, directed cases and randomized traffic.
module tb_k_load_store_unit;

    localparam int unsigned ADDR_W = 8;
    localparam bit [1:0] B = 2'd0, H = 2'd1, W = 2'd2, X = 2'd3;

    logic              K_clk = 1'b0;
    logic              K_rst_n = 1'b0;
    logic              K_req_valid = 1'b0;
    logic              K_req_ready;
    logic              K_req_write = 1'b0;
    logic [1:0]        K_req_size = 2'd0;
    logic              K_req_unsigned = 1'b0;
    logic [31:0]       K_req_addr = 32'h0;
    logic [31:0]       K_req_wdata = 32'h0;
    logic              K_rsp_valid;
    logic [31:0]       K_rsp_rdata;
    logic              K_rsp_err;
    logic [ADDR_W-1:0] K_mem_addr;
    logic              K_mem_we;
    logic [31:0]       K_mem_wdata;
    logic [31:0]       K_mem_rdata;

    k_load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .K_clk(K_clk), .K_rst_n(K_rst_n),
        .K_req_valid(K_req_valid), .K_req_ready(K_req_ready),
        .K_req_write(K_req_write), .K_req_size(K_req_size),
        .K_req_unsigned(K_req_unsigned), .K_req_addr(K_req_addr),
        .K_req_wdata(K_req_wdata), .K_rsp_valid(K_rsp_valid),
        .K_rsp_rdata(K_rsp_rdata), .K_rsp_err(K_rsp_err),
        .K_mem_addr(K_mem_addr), .K_mem_we(K_mem_we),
        .K_mem_wdata(K_mem_wdata), .K_mem_rdata(K_mem_rdata)
    );

    always #5 K_clk = ~K_clk;

    logic [31:0] mem [256] = '{default: 32'h0};
    bit   [31:0] ref_mem [256];
    assign K_mem_rdata = mem[K_mem_addr];
    always @(posedge K_clk) if (K_mem_we) mem[K_mem_addr] <= K_mem_wdata;

    typedef struct {bit [31:0] rdata; bit err; int lat; int acc;} rsp_t;
    typedef struct {bit [7:0] a; bit [31:0] d;} wr_t;
    rsp_t exp_q[$];
    wr_t  wr_q[$];
    int checks = 0, failures = 0, cyc = 0;

    always @(posedge K_clk) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: byte-addressed little-endian view of memory.
    task automatic model_req(input bit wr, input bit [1:0] sz, input bit uns,
                             input bit [31:0] a, input bit [31:0] wd, input int acc);
        bit [7:0]  w;
        int        off, nb;
        bit        err;
        bit [31:0] mask, v;
        rsp_t      r;
        wr_t       x;
        w   = a[9:2];
        off = int'(a[1:0]);
        err = (sz == X);
`ifdef LSU_ALIGN_CHECK_EN
        if (sz == H && off % 2 != 0) err = 1'b1;
        if (sz == W && off != 0) err = 1'b1;
`else
        if (sz == H) off = off - off % 2;
        if (sz == W) off = 0;
`endif
        r.acc = acc;
        if (err) begin
            r.rdata = 32'h0; r.err = 1'b1; r.lat = 2;
            exp_q.push_back(r);
            return;
        end
        nb    = (sz == B) ? 1 : (sz == H) ? 2 : 4;
        mask  = (nb == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nb)) - 32'd1;
        r.err = 1'b0;
        if (!wr) begin
            v = (ref_mem[w] >> (8 * off)) & mask;
            if (!uns && nb < 4 && v[8*nb-1]) v = v | ~mask;
            r.rdata = v;
            r.lat   = 3;
        end else begin
            v = ref_mem[w];
            for (int i = 0; i < nb; i++) v[8*(off+i) +: 8] = wd[8*i +: 8];
            ref_mem[w] = v;
            x.a = w; x.d = v;
            wr_q.push_back(x);
            r.rdata = 32'h0;
            r.lat   = (nb == 4) ? 3 : 4;
        end
        exp_q.push_back(r);
    endtask

    // Monitor: compares every response pulse and every write strobe.
    always @(negedge K_clk) begin
        if (K_rst_n) begin
            if (K_rsp_valid) begin : rsp_chk
                rsp_t e;
                if (exp_q.size() == 0) begin
                    check32("unexpected_rsp_valid", 32'(K_rsp_valid), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check32("rsp_rdata", K_rsp_rdata, e.rdata);
                    check32("rsp_err", 32'(K_rsp_err), 32'(e.err));
                    check32("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
                end
            end
            if (K_mem_we) begin : wr_chk
                wr_t x;
                if (wr_q.size() == 0) begin
                    check32("unexpected_mem_we", 32'(K_mem_we), 32'h0);
                end else begin
                    x = wr_q.pop_front();
                    check32("mem_we_addr", 32'(K_mem_addr), 32'(x.a));
                    check32("mem_we_data", K_mem_wdata, x.d);
                end
            end
        end
    end

    // Called at a negedge; holds valid until accepted, returns at the next negedge.
    task automatic issue(input bit wr, input bit [1:0] sz, input bit uns,
                         input bit [31:0] a, input bit [31:0] wd);
        int g = 0;
        K_req_valid = 1'b1; K_req_write = wr; K_req_size = sz;
        K_req_unsigned = uns; K_req_addr = a; K_req_wdata = wd;
        while (!K_req_ready && g < 50) begin
            @(negedge K_clk);
            g++;
        end
        if (!K_req_ready) begin
            check32("ready_timeout", 32'(K_req_ready), 32'h1);
            K_req_valid = 1'b0;
            return;
        end
        check32("accept_with_outstanding", 32'(exp_q.size()), 32'h0);
        model_req(wr, sz, uns, a, wd, cyc);
        @(negedge K_clk);
        K_req_valid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while ((exp_q.size() != 0 || wr_q.size() != 0) && g < 100) begin
            @(negedge K_clk);
            g++;
        end
        check32("drain_pending", 32'(exp_q.size() + wr_q.size()), 32'h0);
        repeat (2) @(negedge K_clk);
    endtask

    initial begin
        int g;
        repeat (2) @(posedge K_clk);
        @(negedge K_clk);
        check32("reset_ready", 32'(K_req_ready), 32'h1);
        check32("reset_rsp_valid", 32'(K_rsp_valid), 32'h0);
        check32("reset_rsp_rdata", K_rsp_rdata, 32'h0);
        check32("reset_rsp_err", 32'(K_rsp_err), 32'h0);
        check32("reset_mem_we", 32'(K_mem_we), 32'h0);
        check32("reset_mem_addr", 32'(K_mem_addr), 32'h0);
        check32("reset_mem_wdata", K_mem_wdata, 32'h0);
        K_rst_n = 1'b1;
        @(negedge K_clk);

        // Directed cases; back-to-back issues keep valid high while busy.
        issue(1, W, 0, 32'h10, 32'hDEAD_BEEF);
        issue(0, W, 0, 32'h10, 32'h0);
        issue(1, W, 0, 32'h10, 32'h1122_3344);
        issue(1, B, 0, 32'h11, 32'h0000_00AA);
        issue(0, B, 0, 32'h11, 32'h0);
        issue(0, B, 1, 32'h11, 32'h0);
        issue(0, H, 0, 32'h13, 32'h0);
        issue(0, X, 0, 32'h0,  32'h0);
        issue(1, X, 0, 32'h4,  32'h1234_5678);
        issue(0, H, 1, 32'h412, 32'h0);
        issue(1, W, 0, 32'h20, 32'hCAFE_F00D);
        drain();
        check32("sb_merge_word4", mem[4], 32'h1122_AA44);
        check32("sw_word8", mem[8], 32'hCAFE_F00D);

        // Reset while an RMW halfword store is in its READ cycle.
        K_req_valid = 1'b1; K_req_write = 1'b1; K_req_size = H;
        K_req_unsigned = 1'b0; K_req_addr = 32'h20; K_req_wdata = 32'h0000_5555;
        g = 0;
        while (!K_req_ready && g < 20) begin
            @(negedge K_clk);
            g++;
        end
        check32("rst_test_ready", 32'(K_req_ready), 32'h1);
        @(negedge K_clk);
        K_req_valid = 1'b0;
        @(negedge K_clk);
        check32("rmw_read_no_we", 32'(K_mem_we), 32'h0);
        K_rst_n = 1'b0;
        @(posedge K_clk);
        #1;
        check32("midrst_ready", 32'(K_req_ready), 32'h1);
        check32("midrst_mem_we", 32'(K_mem_we), 32'h0);
        check32("midrst_rsp_valid", 32'(K_rsp_valid), 32'h0);
        @(negedge K_clk);
        K_rst_n = 1'b1;
        repeat (4) @(negedge K_clk);
        check32("aborted_rmw_word8", mem[8], 32'hCAFE_F00D);

        // Randomized traffic, mostly in a small window to force reuse.
        for (int n = 0; n < 400; n++) begin
            bit [1:0]  sz;
            bit [31:0] a;
            sz = ($urandom_range(0, 15) == 0) ? X : 2'($urandom_range(0, 2));
            a  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 127));
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
        end
        drain();

        for (int i = 0; i < 256; i++) check32("final_mem", mem[i], ref_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
